// File: rtl/mmio_out_port.sv
// Memory-mapped output port: stores to TXDATA queue words in a FIFO that drains
// over a valid/ready stream; loads return status, control and a sent-word count.
module mmio_out_port #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int          DEPTH     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        sel,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_SENT   = 2'd3;

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic          ovf_r;
   logic          en_r;
   logic [31:0]   sent_r;

   logic          wr_s;
   logic          empty_s;
   logic          full_s;
   logic          push_req_s;
   logic          push_s;
   logic          pop_s;
   logic          flush_s;
   logic          ovf_set_s;
   logic          ovf_clr_s;
   logic          en_wr_s;
   logic [31:0]   status_s;
   logic          unused_s;

   assign sel        = (a[31:4] == BASE_ADDR[31:4]);
   assign wr_s       = we && sel;
   assign empty_s    = (count_r == {CW{1'b0}});
   assign full_s     = (count_r == CNT_FULL);
   assign out_valid  = en_r && !empty_s;
   assign out_data   = mem_r[head_r];
   assign pop_s      = out_valid && out_ready;
   assign push_req_s = wr_s && (a[3:2] == REG_TXDATA);
   assign en_wr_s    = wr_s && (a[3:2] == REG_CTRL);
   assign flush_s    = en_wr_s && wd[1];
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push_s     = push_req_s && !flush_s && (!full_s || pop_s);
   assign ovf_set_s  = push_req_s && !flush_s && full_s && !pop_s;
   assign ovf_clr_s  = wr_s && (a[3:2] == REG_STATUS) && wd[2];
   assign unused_s   = ^a[1:0];

   // STATUS register image.
   always_comb begin
      status_s           = 32'd0;
      status_s[8 +: CW]  = count_r;
      status_s[3]        = en_r;
      status_s[2]        = ovf_r;
      status_s[1]        = full_s;
      status_s[0]        = empty_s;
   end

   // Load data mux; zero outside the window.
   always_comb begin
      rd = 32'd0;
      if (sel) begin
         case (a[3:2])
            REG_STATUS: rd = status_s;
            REG_CTRL:   rd = {31'd0, en_r};
            REG_SENT:   rd = sent_r;
            default:    rd = 32'd0;
         endcase
      end else begin
         rd = 32'd0;
      end
   end

   // FIFO storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[tail_r] <= wd;
      end
   end

   // Pointers, count, control and counters; flush overrides push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {AW{1'b0}};
         tail_r  <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
         ovf_r   <= 1'b0;
         en_r    <= 1'b0;
         sent_r  <= 32'd0;
      end else begin
         if (pop_s) begin
            sent_r <= sent_r + 32'd1;
         end
         if (flush_s) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
         end else begin
            if (push_s) begin
               tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
               head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CNT_ONE;
               2'b01:   count_r <= count_r - CNT_ONE;
               default: count_r <= count_r;
            endcase
         end
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
         end
         if (en_wr_s) begin
            en_r <= wd[0];
         end
      end
   end

endmodule

// File: tb/tb_mmio_out_port.sv
// Randomized bench for mmio_out_port: a queue-based reference model predicts
// loads and the output stream; a separate monitor checks emitted words.
module tb_mmio_out_port;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] wd = 32'd0;
   logic [31:0] rd;
   logic        sel;
   logic [31:0] out_data;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   int unsigned mq[$];
   int unsigned sb_q[$];
   bit          m_en = 1'b0;
   bit          m_ovf = 1'b0;
   int unsigned m_sent = 0;
   bit          started = 1'b0;
   logic [31:0] last_rd;

   mmio_out_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .sel(sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] addr);
      logic [31:0] r;
      r = 32'd0;
      if (addr[31:4] == BASE[31:4]) begin
         case (addr[3:2])
            2'd1: begin
               r = 32'(mq.size()) << 8;
               r[3] = m_en;
               r[2] = m_ovf;
               r[1] = (mq.size() == DEPTH);
               r[0] = (mq.size() == 0);
            end
            2'd2: r = {31'd0, m_en};
            2'd3: r = m_sent;
            default: r = 32'd0;
         endcase
      end
      return r;
   endfunction

   // One bus cycle: drive, check combinational outputs, then advance the model.
   task automatic cyc(input bit w, input logic [31:0] addr, input logic [31:0] data,
                      input bit rdy, input bit rst);
      bit hs;
      bit can_push;
      @(negedge clk);
      #1;
      we = w; a = addr; wd = data; out_ready = rdy; reset = rst;
      #1;
      last_rd = rd;
      if (rst) begin
         mq.delete();
         m_en = 1'b0; m_ovf = 1'b0; m_sent = 0;
      end else begin
         check("sel", 32'(sel), 32'(addr[31:4] == BASE[31:4]));
         check("rd", rd, model_rd(addr));
         check("out_valid", 32'(out_valid), 32'(m_en && mq.size() > 0));
         hs = m_en && (mq.size() > 0) && rdy;
         can_push = (mq.size() < DEPTH) || hs;
         if (hs) begin
            sb_q.push_back(mq.pop_front());
            m_sent++;
         end
         if (w && addr[31:4] == BASE[31:4]) begin
            case (addr[3:2])
               2'd0: if (can_push) mq.push_back(data); else m_ovf = 1'b1;
               2'd1: if (data[2]) m_ovf = 1'b0;
               2'd2: begin
                  m_en = data[0];
                  if (data[1]) mq.delete();
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic st(input logic [3:0] off, input logic [31:0] data, input bit rdy);
      cyc(1'b1, BASE + 32'(off), data, rdy, 1'b0);
   endtask

   task automatic ld(input string name, input logic [3:0] off, input logic [31:0] exp, input bit rdy);
      cyc(1'b0, BASE + 32'(off), 32'd0, rdy, 1'b0);
      check(name, last_rd, exp);
   endtask

   // Monitor: every DUT handshake must match the next predicted word.
   always @(negedge clk) begin
      int unsigned exp;
      #3;
      if (started && !reset) begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL handshake: unexpected word %h, none predicted", out_data);
            end else begin
               exp = sb_q.pop_front();
               if (out_data !== exp) begin
                  errors++;
                  $display("FAIL out_data: got %h expected %h at %0t", out_data, exp, $time);
               end
            end
         end else if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL handshake: missing, expected word %h at %0t", sb_q[0], $time);
            sb_q.delete();
         end
      end
   end

   initial begin
      logic [31:0] addr;
      logic [31:0] data;
      cyc(1'b0, BASE + 32'h4, 32'd0, 1'b0, 1'b1);
      cyc(1'b0, BASE + 32'h4, 32'd0, 1'b0, 1'b1);
      started = 1'b1;
      ld("reset_status", 4'h4, 32'h0000_0001, 1'b1);

      st(4'h8, 32'h1, 1'b1);
      st(4'h0, 32'hA, 1'b1);
      st(4'h0, 32'hB, 1'b1);
      st(4'h0, 32'hC, 1'b1);
      ld("ctrl_en", 4'h8, 32'h1, 1'b1);
      ld("sent3", 4'hC, 32'd3, 1'b1);
      ld("status_idle", 4'h4, 32'h0000_0009, 1'b1);

      st(4'h8, 32'h0, 1'b0);
      for (int i = 0; i < 9; i++) st(4'h0, 32'h100 + 32'(i), 1'b0);
      ld("status_ovf", 4'h4, 32'h0000_0806, 1'b0);
      st(4'h4, 32'h4, 1'b0);
      ld("status_ovf_clr", 4'h4, 32'h0000_0802, 1'b0);
      st(4'h8, 32'h1, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b0, BASE, 32'd0, 1'b1, 1'b0);
      ld("status_drained", 4'h4, 32'h0000_0009, 1'b0);

      st(4'h8, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) st(4'h0, 32'h200 + 32'(i), 1'b0);
      st(4'h8, 32'h1, 1'b0);
      st(4'h0, 32'h55, 1'b1);
      ld("status_full_pp", 4'h4, 32'h0000_080A, 1'b0);
      for (int i = 0; i < 9; i++) cyc(1'b0, BASE, 32'd0, 1'b1, 1'b0);

      st(4'h8, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) st(4'h0, 32'h300 + 32'(i), 1'b0);
      st(4'h8, 32'h1, 1'b0);
      ld("sent_before_flush", 4'hC, 32'd20, 1'b0);
      st(4'h8, 32'h3, 1'b1);
      ld("status_flush", 4'h4, 32'h0000_0009, 1'b0);
      ld("sent_flush", 4'hC, 32'd21, 1'b0);
      ld("ctrl_after_flush", 4'h8, 32'h1, 1'b0);

      ld("outside_rd", 4'h0, 32'd0, 1'b0);
      cyc(1'b1, BASE + 32'h10, 32'h3, 1'b0, 1'b0);
      check("outside_sel", 32'(sel), 32'd0);
      check("outside_rd", last_rd, 32'd0);
      ld("outside_nochange", 4'h8, 32'h1, 1'b0);

      for (int i = 0; i < 4; i++) st(4'h0, 32'h400 + 32'(i), 1'b0);
      cyc(1'b0, BASE, 32'd0, 1'b1, 1'b0);
      cyc(1'b0, BASE, 32'd0, 1'b1, 1'b1);
      ld("sent_after_reset", 4'hC, 32'd0, 1'b1);
      ld("status_after_reset", 4'h4, 32'h0000_0001, 1'b1);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(15, 0) == 0) addr = BASE + 32'h10 + 32'($urandom_range(255, 0));
         else addr = BASE + 32'($urandom_range(15, 0));
         data = $urandom;
         if (addr[3:2] == 2'd2)
            data[1:0] = {($urandom_range(9, 0) == 0), ($urandom_range(3, 0) != 0)};
         else if (addr[3:2] == 2'd1)
            data[2] = ($urandom_range(3, 0) == 0);
         cyc(($urandom_range(1, 0) == 1), addr, data, ($urandom_range(9, 0) < 7),
             ($urandom_range(499, 0) == 0));
      end

      st(4'h8, 32'h1, 1'b1);
      for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, BASE + 32'h4, 32'd0, 1'b1, 1'b0);
      ld("final_status", 4'h4, 32'h0000_0009, 1'b1);
      @(negedge clk);
      #4;
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_out_port.md
# mmio_out_port

Memory-mapped output port that sits on the processor's data-memory bus beside `dmem` and responds to loads and stores in a 16-byte address window. Stores to its data register push words into an internal FIFO. The FIFO drains to an external consumer over a valid/ready stream. Loads return FIFO status, control state and a sent-word counter combinationally, so the block can be muxed into `ReadData` in the same memory stage as `dmem`.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_0000: window base. Must be 16-byte aligned.
- `DEPTH`, 8: FIFO depth in words. Power of two, 2..128.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  store strobe from the memory stage (`MemWriteM`).
- `a`  in  32  byte address (`DataAdr`).
- `wd`  in  32  store data (`WriteData`).
- `rd`  out  32  load data. Combinational. 0 when `sel`=0.
- `sel`  out  1  combinational; 1 when `a[31:4]==BASE_ADDR[31:4]`. The top level uses it to mux `rd` and to suppress `dmem` writes.
- `out_data`  out  32  FIFO head word.
- `out_valid`  out  1  head word valid.
- `out_ready`  in  1  consumer accepts the head word.

## Operation
- Decode uses `a[3:2]`. `a[1:0]` is ignored; only full-word accesses are defined. A store takes effect only when `we && sel`.
- 0x0 TXDATA:
  - Store: push `wd` if a slot is free.
  - Store when full with no simultaneous pop: data dropped and sticky `OVF` set.
  - Load returns 0.
- 0x4 STATUS, load layout:
  - bit0 `EMPTY`, bit1 `FULL`, bit2 `OVF`, bit3 `EN`.
  - bits[15:8] `COUNT` (0..DEPTH).
  - Other bits 0.
  - Store with `wd[2]`=1 clears `OVF`; other bits are ignored.
- 0x8 CTRL:
  - Store: bit0 writes `EN`. bit1=1 flushes the FIFO (self-clearing, never reads back).
  - Load returns {30'b0, 1'b0, EN}.
- 0xC SENT: 32-bit count of completed output handshakes. Wraps from 0xFFFF_FFFF to 0. Read-only; stores are ignored.
- Output stream:
  - `out_valid = EN && !EMPTY`; `out_data` = head word.
  - Handshake occurs when `out_valid && out_ready` at the rising edge. It pops the head and increments SENT.
  - With `EN`=0 the FIFO holds its contents and `out_valid` is 0.
  - Once `out_valid` rises, `out_data` stays stable until the handshake.
- FIFO structure: head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH. `COUNT` is log2(DEPTH)+1 bits.
- Simultaneous events:
  - Push and pop in the same cycle: both occur, `COUNT` unchanged. This applies when full as well; the push is accepted and `OVF` is not set.
  - Push into an empty FIFO: the word becomes visible on `out_data`/`out_valid` the next cycle. There is no fall-through.
  - Flush and push in the same cycle: flush wins, the pushed word is discarded, `OVF` is unaffected.
  - Flush and handshake in the same cycle: the FIFO empties and SENT still increments.
  - Store to STATUS clearing `OVF` in the same cycle as an overflowing push is impossible (single bus). `OVF` set and clear never collide.

## Timing
- Reset values, applied at the first rising edge with `reset`=1: pointers 0, `COUNT` 0, `OVF` 0, `EN` 0, SENT 0.
  - Outputs then: `out_valid`=0, `out_data`=don't-care (FIFO RAM is not reset).
  - `rd` and `sel` are combinational and unaffected by reset except through register contents.
- Reset mid-operation discards all queued words; no handshake completes in a reset cycle.
- Load latency: 0 cycles. `rd` reflects state before the current edge.
- Store latency: 1 cycle. A store at edge N is visible in `rd`, `out_valid` and `COUNT` after edge N.
- Maximum throughput: one push and one pop per cycle.

## Test plan
- Reset, then STATUS load -> `rd`=0x0000_0001. `out_valid`=0.
- EN=1 (store 0x1 to +0x8), store 0xA, 0xB, 0xC to +0x0, `out_ready`=1 -> `out_data` 0xA, 0xB, 0xC on three consecutive handshakes. SENT reads 3. STATUS reads 0x0000_0009.
- EN=0, DEPTH=8: 9 stores -> STATUS = 0x0000_0806 (COUNT 8, FULL, OVF). Store 0x4 to STATUS -> 0x0000_0802. Set EN with `out_ready`=1 -> first 8 words drain in order; the 9th was never queued.
- Full FIFO, EN=1, `out_ready`=1, store 0x55 in the same cycle -> `COUNT` stays 8, OVF stays 0, 0x55 emerges ninth.
- FIFO holding 3 words: flush (store 0x3 to CTRL) together with a TXDATA-free handshake cycle -> next cycle STATUS=0x0000_0009 and SENT incremented by 1. Load of CTRL returns 0x1.
- Access to `BASE_ADDR`+0x10 -> `sel`=0, `rd`=0, no state change. Assert `reset` mid-drain -> `out_valid`=0 and SENT=0 next cycle.
